// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU: opcode encoding,
// flag register layout, flag write masks and default saturation limits.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_LANE  = 4;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_XOR    = 3'd2,
    OP_RED    = 3'd3,
    OP_SLL    = 3'd4,
    OP_SRA    = 3'd5,
    OP_ROR    = 3'd6,
    OP_PADSUB = 3'd7
  } alu_op_e;

  // flags_q layout is {Z,V,N}
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam logic [ALU_WIDTH-1:0] SAT_MAX = {1'b0, {(ALU_WIDTH-1){1'b1}}};
  localparam logic [ALU_WIDTH-1:0] SAT_MIN = {1'b1, {(ALU_WIDTH-1){1'b0}}};

  function automatic logic [2:0] flag_mask(input alu_op_e op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB: begin
        m[FLAG_Z] = 1'b1;
        m[FLAG_V] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: saturating ADD/SUB, XOR, shifts/rotate,
// per-lane saturating add (PADSUB) and lane-sum reduction (RED).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int LANE  = ALU_LANE,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int NL = WIDTH / LANE;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LMIN = {1'b1, {(LANE-1){1'b0}}};

  logic [WIDTH-1:0]   add_raw, sub_raw;
  logic               add_ovf, sub_ovf;
  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] ror_wide;
  logic [WIDTH-1:0]   sll_res, sra_res;
  logic [WIDTH-1:0]   pad_res;
  logic [NL-1:0]      lane_ovf;
  logic [WIDTH-1:0]   red_term [NL];
  logic [WIDTH-1:0]   red_sum;

  assign add_raw = a + b;
  assign sub_raw = a - b;
  // Overflow is only possible when the operand signs make it so; the
  // saturation direction then follows the sign of a.
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_raw[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_raw[WIDTH-1] != a[WIDTH-1]);

  assign amt      = b[SHW-1:0];
  assign sll_res  = a << amt;
  assign sra_res  = $signed(a) >>> amt;
  assign ror_wide = {a, a} >> amt;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic [LANE-1:0] la, lb;
    logic [LANE:0]   lsum;
    assign la   = a[i*LANE +: LANE];
    assign lb   = b[i*LANE +: LANE];
    assign lsum = {la[LANE-1], la} + {lb[LANE-1], lb};
    assign lane_ovf[i] = lsum[LANE] != lsum[LANE-1];
    assign pad_res[i*LANE +: LANE] = lane_ovf[i] ? (lsum[LANE] ? LMIN : LMAX)
                                                 : lsum[LANE-1:0];
    assign red_term[i] = {{(WIDTH-LANE-1){lsum[LANE]}}, lsum};
  end

  always_comb begin
    red_sum = '0;
    for (int i = 0; i < NL; i++) red_sum = red_sum + red_term[i];
  end

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_ADD: begin
        result = add_ovf ? (a[WIDTH-1] ? SMIN : SMAX) : add_raw;
        err    = add_ovf;
      end
      OP_SUB: begin
        result = sub_ovf ? (a[WIDTH-1] ? SMIN : SMAX) : sub_raw;
        err    = sub_ovf;
      end
      OP_XOR: result = a ^ b;
      OP_RED: result = red_sum;
      OP_SLL: result = sll_res;
      OP_SRA: result = sra_res;
      OP_ROR: result = ror_wide[WIDTH-1:0];
      OP_PADSUB: begin
        result = pad_res;
        err    = |lane_ovf;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with flush and a {Z,V,N} flag register
// that updates only when a result is committed to the consumer.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int LANE  = ALU_LANE,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic [2:0]       flags_q,
  output logic             flags_wr
);

  // Handshake: a transfer happens on an edge where valid && ready; a
  // stage's payload is held stable while its valid is high and it cannot move.
  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  alu_op_e          s1_op;
  logic [2:0]       s2_mask;
  logic             s2_free, s1_adv, accept, commit;
  logic [WIDTH-1:0] core_result;
  logic             core_err;
  logic [2:0]       flags_new;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !flush && (!s1_valid || s1_adv);
  assign accept   = in_valid && in_ready;
  assign commit   = s2_valid && out_ready && !flush;
  assign out_valid = s2_valid;

  alu_core #(.WIDTH(WIDTH), .LANE(LANE), .SHW(SHW)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .err    (core_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= OP_ADD;
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
      s2_mask    <= 3'b000;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_op    <= alu_op_e'(in_op);
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid   <= 1'b1;
        out_result <= core_result;
        out_err    <= core_err;
        s2_mask    <= flag_mask(s1_op);
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    flags_new         = 3'b000;
    flags_new[FLAG_Z] = (out_result == '0);
    flags_new[FLAG_V] = out_err;
    flags_new[FLAG_N] = out_result[WIDTH-1];
  end

  // Only the bits selected by the committing op's mask are written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 3'b000;
      flags_wr <= 1'b0;
    end else begin
      flags_wr <= commit && (|s2_mask);
      if (commit) flags_q <= (flags_q & ~s2_mask) | (flags_new & s2_mask);
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: hand-computed results go into a scoreboard
// queue; a negedge monitor pops and checks every committed beat and the flags.
module tb_alu_pipe;

  localparam int W = 16;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, RED = 3'd3,
                         SLL = 3'd4, SRA = 3'd5, ROR = 3'd6, PAD = 3'd7;

  logic         clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic         out_err, flags_wr;
  logic [W-1:0] in_a, in_b, out_result;
  logic [2:0]   in_op, flags_q;

  // entry = {op, err, result}
  logic [W+3:0] exp_q[$];
  int           nvec, nfail, stall_seen;
  logic [2:0]   model_flags, saved_flags;
  logic         pend_wr, held;
  logic [W-1:0] held_res;
  logic         held_err;

  alu_pipe #(.WIDTH(W), .LANE(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err),
    .flags_q(flags_q), .flags_wr(flags_wr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] res, input logic err);
    int n;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back({op, err, res});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic check_lat(input string name);
    idle();
    @(negedge clk); chk({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk({name, "_lat2"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, exp_q.size() != 0 || out_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W+3:0] e;
    if (!rst_n) begin
      pend_wr = 1'b0;
      held    = 1'b0;
    end else begin
      chk("flags_q", {29'd0, flags_q}, {29'd0, model_flags});
      chk("flags_wr", {31'd0, flags_wr}, {31'd0, pend_wr});
      pend_wr = 1'b0;
      if (in_valid && !in_ready && !flush) stall_seen++;
      if (out_valid && !out_ready) begin
        if (held) begin
          chk("stall_result", {16'd0, out_result}, {16'd0, held_res});
          chk("stall_err", {31'd0, out_err}, {31'd0, held_err});
        end
        held = 1'b1; held_res = out_result; held_err = out_err;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {16'd0, out_result}, 32'hdead);
        end else begin
          e = exp_q.pop_front();
          chk("result", {16'd0, out_result}, {16'd0, e[W-1:0]});
          chk("err", {31'd0, out_err}, {31'd0, e[W]});
          case (e[W+3:W+1])
            ADD, SUB: begin
              model_flags = {e[W-1:0] == '0, e[W], e[W-1]};
              pend_wr = 1'b1;
            end
            XOR, SLL, SRA, ROR: begin
              model_flags[2] = (e[W-1:0] == '0);
              pend_wr = 1'b1;
            end
            default: pend_wr = 1'b0;
          endcase
        end
      end
    end
  end

  initial begin
    nvec = 0; nfail = 0; stall_seen = 0;
    model_flags = 3'b000; pend_wr = 1'b0; held = 1'b0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = ADD;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {16'd0, out_result}, 32'd0);
    chk("rst_flags", {29'd0, flags_q}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // saturation and flag behaviour
    send(ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1);
    check_lat("add_sat");
    drain();
    chk("flags_after_add", {29'd0, flags_q}, 32'b010);
    send(SUB, 16'h8000, 16'h0001, 16'h8000, 1'b1);
    send(XOR, 16'h00FF, 16'h00FF, 16'h0000, 1'b0);
    drain();
    chk("flags_after_xor", {29'd0, flags_q}, 32'b111);

    // back-to-back with a mid-stream stall
    stall_seen = 0;
    fork
      begin
        send(ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0);
        send(SUB, 16'h0002, 16'h0005, 16'hFFFD, 1'b0);
        send(XOR, 16'h1234, 16'h00FF, 16'h12CB, 1'b0);
        send(ADD, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
      end
      begin
        @(posedge clk); @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("in_ready_dropped", {31'd0, stall_seen > 0}, 32'd1);
    chk("flags_after_burst", {29'd0, flags_q}, 32'b001);

    // lane ops leave flags alone
    send(PAD, 16'h7171, 16'h1111, 16'h7272, 1'b1);
    send(PAD, 16'h8888, 16'h8888, 16'h8888, 1'b1);
    send(RED, 16'h1234, 16'h1111, 16'h000E, 1'b0);
    send(RED, 16'hFFFF, 16'h8888, 16'hFFDC, 1'b0);
    send(ADD, 16'h8000, 16'h8000, 16'h8000, 1'b1);
    // shifts touch Z only
    send(SRA, 16'h8000, 16'h000F, 16'hFFFF, 1'b0);
    send(ROR, 16'h0001, 16'h0001, 16'h8000, 1'b0);
    send(ROR, 16'h00F1, 16'h0004, 16'h100F, 1'b0);
    send(SLL, 16'h00F0, 16'h000C, 16'h0000, 1'b0);
    send(SLL, 16'h0001, 16'h0000, 16'h0001, 1'b0);
    drain();
    chk("flags_after_shifts", {29'd0, flags_q}, 32'b011);

    // flush kills the stage-2 ADD 0+0 and blocks a coincident accept
    send(ADD, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    idle();
    @(posedge clk); #1;
    flush = 1'b1; saved_flags = flags_q;
    in_valid = 1'b1; in_op = ADD; in_a = 16'h0001; in_b = 16'h0001;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    chk("flush_beat_present", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty", {31'd0, out_valid}, 32'd0);
    chk("flush_flags_held", {29'd0, flags_q}, {29'd0, saved_flags});
    @(posedge clk); #1;

    // async reset mid-stream drops in-flight ops
    send(SUB, 16'h0005, 16'h0003, 16'h0002, 1'b0);
    send(XOR, 16'h0F0F, 16'h00FF, 16'h0FF0, 1'b0);
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    model_flags = 3'b000;
    @(negedge clk);
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_result", {16'd0, out_result}, 32'd0);
    chk("rst2_err", {31'd0, out_err}, 32'd0);
    chk("rst2_flags", {29'd0, flags_q}, 32'd0);
    chk("rst2_flags_wr", {31'd0, flags_wr}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    check_lat("post_reset");
    drain();
    chk("flags_post_reset", {29'd0, flags_q}, 32'b000);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
